// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer write controller: opcodes, FSM states,
// framebuffer size and the bit layout of the status byte returned to the SPI master.
package fb_pkg;

   localparam int FB_BYTES = 38400;

   localparam logic [7:0] OP_WRITE   = 8'h01;
   localparam logic [7:0] OP_FILL    = 8'h02;
   localparam logic [7:0] OP_CLR_ERR = 8'h03;

   localparam int ST_BUSY      = 7;
   localparam int ST_ERR_OP    = 6;
   localparam int ST_ERR_RANGE = 5;
   localparam int ST_ERR_OVR   = 4;

   typedef enum logic [2:0] {
      IDLE,
      OPCODE,
      ADDR_HI,
      ADDR_LO,
      DATA,
      FILL_VAL,
      FILLING,
      DISCARD
   } state_t;

   function automatic logic [7:0] status_byte(input logic busy, input logic err_op,
                                              input logic err_range, input logic err_ovr);
      logic [7:0] s;
      s               = '0;
      s[ST_BUSY]      = busy;
      s[ST_ERR_OP]    = err_op;
      s[ST_ERR_RANGE] = err_range;
      s[ST_ERR_OVR]   = err_ovr;
      return s;
   endfunction

endpackage

// File: rtl/fb_fill_engine.sv
// Full-screen fill: once started, writes one byte per cycle to addresses
// 0..FB_BYTES-1 in ascending order, then drops busy.
module fb_fill_engine #(
   parameter int FB_BYTES = 38400,
   parameter int ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [7:0]        value,
   output logic              busy,
   output logic              done,
   output logic              wr_en,
   output logic [ADDR_W-1:0] addr,
   output logic [7:0]        data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

   assign wr_en = busy;
   // done marks the cycle carrying the final write; busy is low from the next cycle.
   assign done  = busy && (addr == LAST_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         addr <= '0;
         data <= '0;
      end else if (start) begin
         busy <= 1'b1;
         addr <= '0;
         data <= value;
      end else if (busy) begin
         if (addr == LAST_ADDR) busy <= 1'b0;
         else                   addr <= addr + ADDR_W'(1);
      end
   end

endmodule

// File: rtl/fb_write_ctrl.sv
// SPI packet decoder and write-port arbiter for the 640x480 1bpp screen RAM:
// byte writes with auto-increment, hardware fill, and a per-packet status byte.
module fb_write_ctrl #(
   parameter int FB_BYTES = fb_pkg::FB_BYTES,
   parameter int ADDR_W   = 16,
   parameter int CS_SYNC  = 2
) (
   input  logic              i_Clk,
   input  logic              i_Rst_L,
   input  logic              i_SPI_CS_n,
   input  logic              i_RX_DV,
   input  logic [7:0]        i_RX_Byte,
   output logic [7:0]        o_TX_Byte,
   output logic              o_TX_DV,
   output logic              o_Wr_En,
   output logic [ADDR_W-1:0] o_Wr_Addr,
   output logic [7:0]        o_Wr_Data,
   output logic              o_Busy
);

   import fb_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_BYTES - 1);

   logic [CS_SYNC-1:0] cs_sync_q;
   logic               cs_n;
   logic               cs_n_q;
   logic               cs_fall;

   state_t             state;
   logic [7:0]         addr_hi;
   logic [ADDR_W-1:0]  addr;
   logic               err_op;
   logic               err_range;
   logic               err_ovr;
   logic               fill_cs_fell;

   logic               data_wr_en;
   logic [ADDR_W-1:0]  data_wr_addr;
   logic [7:0]         data_wr_data;

   logic               fill_start;
   logic               fill_busy;
   logic               fill_done;
   logic               fill_wr_en;
   logic [ADDR_W-1:0]  fill_addr;
   logic [7:0]         fill_data;

   assign cs_n       = cs_sync_q[CS_SYNC-1];
   assign cs_fall    = cs_n_q & ~cs_n;
   assign fill_start = (state == FILL_VAL) && i_RX_DV && !cs_n;

   // Synchronizer idles high so leaving reset never looks like a packet start.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         cs_sync_q <= '1;
         cs_n_q    <= 1'b1;
      end else begin
         cs_sync_q <= {cs_sync_q[CS_SYNC-2:0], i_SPI_CS_n};
         cs_n_q    <= cs_n;
      end
   end

   fb_fill_engine #(
      .FB_BYTES (FB_BYTES),
      .ADDR_W   (ADDR_W)
   ) u_fill (
      .clk   (i_Clk),
      .rst_n (i_Rst_L),
      .start (fill_start),
      .value (i_RX_Byte),
      .busy  (fill_busy),
      .done  (fill_done),
      .wr_en (fill_wr_en),
      .addr  (fill_addr),
      .data  (fill_data)
   );

   // NOTE: every state update below uses <= so all branches see pre-edge values.
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state        <= IDLE;
         addr_hi      <= '0;
         addr         <= '0;
         err_op       <= 1'b0;
         err_range    <= 1'b0;
         err_ovr      <= 1'b0;
         fill_cs_fell <= 1'b0;
         data_wr_en   <= 1'b0;
         data_wr_addr <= '0;
         data_wr_data <= '0;
         o_TX_DV      <= 1'b0;
         o_TX_Byte    <= '0;
      end else begin
         data_wr_en <= 1'b0;
         o_TX_DV    <= cs_fall;
         if (cs_fall) o_TX_Byte <= status_byte(fill_busy, err_op, err_range, err_ovr);

         if (state == FILLING) begin
            // The fill runs to completion regardless of CS; incoming bytes are lost.
            if (i_RX_DV) err_ovr      <= 1'b1;
            if (cs_fall) fill_cs_fell <= 1'b1;
            if (fill_done) begin
               fill_cs_fell <= 1'b0;
               if (cs_n)                         state <= IDLE;
               else if (fill_cs_fell || cs_fall) state <= DISCARD;
               else                              state <= OPCODE;
            end
         end else if (cs_n) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: state <= OPCODE;
               OPCODE: if (i_RX_DV) begin
                  case (i_RX_Byte)
                     OP_WRITE: state <= ADDR_HI;
                     OP_FILL:  state <= FILL_VAL;
                     OP_CLR_ERR: begin
                        err_op    <= 1'b0;
                        err_range <= 1'b0;
                        err_ovr   <= 1'b0;
                        state     <= DISCARD;
                     end
                     default: begin
                        err_op <= 1'b1;
                        state  <= DISCARD;
                     end
                  endcase
               end
               ADDR_HI: if (i_RX_DV) begin
                  addr_hi <= i_RX_Byte;
                  state   <= ADDR_LO;
               end
               ADDR_LO: if (i_RX_DV) begin
                  if (32'({addr_hi, i_RX_Byte}) >= FB_BYTES) begin
                     err_range <= 1'b1;
                     state     <= DISCARD;
                  end else begin
                     addr  <= ADDR_W'({addr_hi, i_RX_Byte});
                     state <= DATA;
                  end
               end
               DATA: if (i_RX_DV) begin
                  data_wr_en   <= 1'b1;
                  data_wr_addr <= addr;
                  data_wr_data <= i_RX_Byte;
                  addr         <= (addr == LAST_ADDR) ? '0 : addr + ADDR_W'(1);
               end
               FILL_VAL: if (i_RX_DV) state <= FILLING;
               default: ;
            endcase
         end
      end
   end

   // The FSM never has both sources active, so the port select is the fill busy flag.
   assign o_Wr_En   = fill_wr_en | data_wr_en;
   assign o_Wr_Addr = fill_busy ? fill_addr : data_wr_addr;
   assign o_Wr_Data = fill_busy ? fill_data : data_wr_data;
   assign o_Busy    = fill_busy;

endmodule
